// File: rtl/fpnew_pkg.sv
// rtl/fpnew_pkg.sv - shared FPU status type and flag helper
package fpnew_pkg;

  // IEEE exception flags in the usual {NV,DZ,OF,UF,NX} order
  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  // Sticky flags only ever gain bits, so accumulation is a plain OR
  function automatic status_t accumulate_status(input status_t acc, input status_t upd);
    return status_t'(acc | upd);
  endfunction

endpackage

// File: rtl/fpnew_resp_fifo.sv
// rtl/fpnew_resp_fifo.sv - in-order entry FIFO with push/pop/flush and occupancy count
module fpnew_resp_fifo #(
  parameter type         entry_t = logic,
  parameter int unsigned Depth   = 4,
  parameter int unsigned CntW    = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  entry_t          wdata_i,
  input  logic            pop_i,
  output entry_t          rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned     PtrW     = $clog2(Depth);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  entry_t          mem [Depth];
  logic [PtrW-1:0] rptr;
  logic [PtrW-1:0] wptr;
  logic [CntW-1:0] count;
  logic            push_en;
  logic            pop_en;

  assign full_o  = (count == DepthCnt);
  assign empty_o = (count == '0);
  assign count_o = count;
  // Flush wins over any handshake in the same cycle
  assign push_en = push_i & ~full_o & ~flush_i;
  assign pop_en  = pop_i & ~empty_o & ~flush_i;
  // Head is read straight from storage; no fall-through path when empty
  assign rdata_o = mem[rptr];

  // Storage needs no reset: entries are only visible once counted
  always_ff @(posedge clk_i) begin
    if (push_en) mem[wptr] <= wdata_i;
  end

  // Write/read pointers, wrapping explicitly so Depth need not be a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_en) wptr <= (wptr == LastPtr) ? '0 : wptr + 1'b1;
      if (pop_en)  rptr <= (rptr == LastPtr) ? '0 : rptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else if (push_en && !pop_en) begin
      count <= count + 1'b1;
    end else if (pop_en && !push_en) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fpnew_resp_buffer.sv
// rtl/fpnew_resp_buffer.sv - FPU response buffer with in-order retire and sticky flags
module fpnew_resp_buffer import fpnew_pkg::*; #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned Depth   = 4,
  parameter type         TagType = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           result_i,
  input  status_t                    status_i,
  input  TagType                     tag_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           result_o,
  output status_t                    status_o,
  output TagType                     tag_o,
  output logic [4:0]                 fflags_o,
  input  logic                       fflags_clr_i,
  output logic [$clog2(Depth+1)-1:0] usage_o,
  output logic                       busy_o
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    status_t          status;
    TagType           tag;
  } entry_t;

  entry_t  wr_entry;
  entry_t  head;
  logic    full;
  logic    empty;
  logic    pop_fire;
  status_t fflags_q;

  assign wr_entry = '{result: result_i, status: status_i, tag: tag_i};

  fpnew_resp_fifo #(
    .entry_t (entry_t),
    .Depth   (Depth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (in_valid_i),
    .wdata_i (wr_entry),
    .pop_i   (out_ready_i),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (usage_o)
  );

  assign in_ready_o  = ~full;
  assign out_valid_o = ~empty;
  assign result_o    = head.result;
  assign status_o    = head.status;
  assign tag_o       = head.tag;
  assign busy_o      = |usage_o;
  assign fflags_o    = fflags_q;

  // A retire only counts if it is not swallowed by a flush
  assign pop_fire = out_valid_o & out_ready_i & ~flush_i;

  // Sticky flags: clear first, then accumulate the retiring entry's status
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fflags_q <= '0;
    end else if (fflags_clr_i) begin
      fflags_q <= pop_fire ? head.status : '0;
    end else if (pop_fire) begin
      fflags_q <= accumulate_status(fflags_q, head.status);
    end
  end

endmodule

// File: tb/tb_fpnew_resp_buffer.sv
// tb/tb_fpnew_resp_buffer.sv - self-checking bench for fpnew_resp_buffer
module tb_fpnew_resp_buffer;
  import fpnew_pkg::*;

  localparam int DEPTH = 4;
  typedef logic [7:0] tag_t;
  typedef struct packed {
    logic [63:0] r;
    logic [4:0]  s;
    tag_t        t;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] result_in = '0;
  status_t     status_in;
  tag_t        tag_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result_out;
  status_t     status_out;
  tag_t        tag_out;
  logic [4:0]  fflags;
  logic        fflags_clr = 1'b0;
  logic [2:0]  usage;
  logic        busy;

  int passed = 0;
  int total = 0;

  ent_t       q[$];
  logic [4:0] m_flags = '0;

  always #5 clk = ~clk;

  fpnew_resp_buffer #(
    .WIDTH   (64),
    .Depth   (DEPTH),
    .TagType (tag_t)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .result_i     (result_in),
    .status_i     (status_in),
    .tag_i        (tag_in),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .result_o     (result_out),
    .status_o     (status_out),
    .tag_o        (tag_out),
    .fflags_o     (fflags),
    .fflags_clr_i (fflags_clr),
    .usage_o      (usage),
    .busy_o       (busy)
  );

  task automatic idle();
    flush = 0; in_valid = 0; out_ready = 0; fflags_clr = 0;
  endtask

  // One clock of the reference model: a bounded queue plus a flag word
  task automatic tick();
    bit   push_ok;
    bit   pop_ok;
    ent_t e;
    push_ok = in_valid && (q.size() < DEPTH);
    pop_ok  = out_ready && (q.size() > 0);
    e.r = result_in; e.s = status_in; e.t = tag_in;
    @(posedge clk);
    if (flush) begin
      q.delete();
      if (fflags_clr) m_flags = '0;
    end else begin
      if (pop_ok) begin
        ent_t h;
        h = q.pop_front();
        m_flags = fflags_clr ? h.s : (m_flags | h.s);
      end else if (fflags_clr) begin
        m_flags = '0;
      end
      if (push_ok) q.push_back(e);
    end
    #1;
  endtask

  task automatic push_one(input tag_t t, input logic [4:0] s);
    in_valid = 1; tag_in = t; status_in = s; result_in = {$urandom, $urandom};
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (fflags !== 5'b0) $display("FAIL reset_fflags: got %b want 00000", fflags); else passed++;
    total++; if (usage !== 3'd0) $display("FAIL reset_usage: got %0d want 0", usage); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    @(negedge clk);
    rst_n = 1; q.delete(); m_flags = '0;
  endtask

  task automatic test_single();
    in_valid = 1; result_in = 64'h3FF0_0000_0000_0000; status_in = 5'b00001; tag_in = 8'd1;
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else passed++;
    total++; if (result_out !== 64'h3FF0_0000_0000_0000) $display("FAIL single_result: got %h want 3ff0000000000000", result_out); else passed++;
    total++; if (tag_out !== 8'd1) $display("FAIL single_tag: got %0d want 1", tag_out); else passed++;
    tick();
    total++; if (fflags !== 5'b0) $display("FAIL single_flags_before_pop: got %b want 00000", fflags); else passed++;
    out_ready = 1; tick(); out_ready = 0;
    total++; if (fflags !== 5'b00001) $display("FAIL single_flags_after_pop: got %b want 00001", fflags); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL single_empty: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_fill();
    fflags_clr = 1; tick(); fflags_clr = 0;
    for (int i = 0; i < DEPTH; i++) push_one(tag_t'(i), 5'b0);
    total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", in_ready); else passed++;
    total++; if (usage !== 3'd4) $display("FAIL fill_usage: got %0d want 4", usage); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL fill_busy: got %b want 1", busy); else passed++;
    for (int k = 0; k < DEPTH; k++) begin
      total++; if (tag_out !== tag_t'(k)) $display("FAIL fill_order: got %0d want %0d", tag_out, k); else passed++;
      total++; if (result_out !== q[0].r) $display("FAIL fill_result: got %h want %h", result_out, q[0].r); else passed++;
      out_ready = 1; tick(); out_ready = 0;
      if (k == 0) begin
        total++; if (in_ready !== 1'b1) $display("FAIL fill_ready_after_pop: got %b want 1", in_ready); else passed++;
        total++; if (usage !== 3'd3) $display("FAIL fill_usage_after_pop: got %0d want 3", usage); else passed++;
      end
    end
    total++; if (usage !== 3'd0) $display("FAIL fill_drained: got %0d want 0", usage); else passed++;
  endtask

  task automatic test_back_to_back();
    push_one(8'd20, 5'b0);
    push_one(8'd21, 5'b0);
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      tag_in = tag_t'(22 + i); result_in = {$urandom, $urandom}; status_in = 5'b0;
      total++; if (tag_out !== tag_t'(20 + i)) $display("FAIL b2b_tag: got %0d want %0d", tag_out, 20 + i); else passed++;
      tick();
      total++; if (usage !== 3'd2) $display("FAIL b2b_usage: got %0d want 2", usage); else passed++;
    end
    in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      total++; if (tag_out !== tag_t'(30 + i)) $display("FAIL b2b_drain_tag: got %0d want %0d", tag_out, 30 + i); else passed++;
      tick();
    end
    out_ready = 0;
  endtask

  task automatic test_flag_clr();
    fflags_clr = 1; tick(); fflags_clr = 0;
    push_one(8'd40, 5'b00101);
    out_ready = 1; tick(); out_ready = 0;
    total++; if (fflags !== 5'b00101) $display("FAIL clr_prior_flags: got %b want 00101", fflags); else passed++;
    push_one(8'd41, 5'b10000);
    out_ready = 1; fflags_clr = 1; tick(); out_ready = 0; fflags_clr = 0;
    total++; if (fflags !== 5'b10000) $display("FAIL clr_with_pop: got %b want 10000", fflags); else passed++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push_one(tag_t'(50 + i), 5'b00010);
    in_valid = 1; out_ready = 1; flush = 1; tag_in = 8'd60; status_in = 5'b00100;
    tick();
    idle();
    total++; if (usage !== 3'd0) $display("FAIL flush_usage: got %0d want 0", usage); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy); else passed++;
    total++; if (fflags !== 5'b10000) $display("FAIL flush_fflags: got %b want 10000", fflags); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) push_one(tag_t'(70 + i), 5'b01000);
    out_ready = 1; fflags_clr = 1; tick(); out_ready = 0; fflags_clr = 0;
    total++; if (fflags !== 5'b01000) $display("FAIL areset_pre_flags: got %b want 01000", fflags); else passed++;
    total++; if (usage !== 3'd2) $display("FAIL areset_pre_usage: got %0d want 2", usage); else passed++;
    #2 rst_n = 0;
    #1;
    total++; if (usage !== 3'd0) $display("FAIL areset_usage: got %0d want 0", usage); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL areset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (fflags !== 5'b0) $display("FAIL areset_fflags: got %b want 00000", fflags); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", busy); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready: got %b want 1", in_ready); else passed++;
    q.delete(); m_flags = '0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    tag_t next_tag;
    next_tag = 8'd100;
    for (int c = 0; c < 400; c++) begin
      if (!(in_valid && q.size() >= DEPTH)) begin
        in_valid = ($urandom_range(0, 99) < 55);
        tag_in = next_tag; next_tag = next_tag + 1'b1;
        status_in = 5'($urandom);
        result_in = {$urandom, $urandom};
      end
      out_ready  = ($urandom_range(0, 99) < 60);
      flush      = ($urandom_range(0, 31) == 0);
      fflags_clr = ($urandom_range(0, 15) == 0);
      total++; if (in_ready !== (q.size() < DEPTH)) $display("FAIL rnd_in_ready c=%0d: got %b want %b", c, in_ready, q.size() < DEPTH); else passed++;
      total++; if (out_valid !== (q.size() > 0)) $display("FAIL rnd_out_valid c=%0d: got %b want %b", c, out_valid, q.size() > 0); else passed++;
      if (q.size() > 0) begin
        total++;
        if ({result_out, status_out, tag_out} !== {q[0].r, q[0].s, q[0].t})
          $display("FAIL rnd_head c=%0d: got %h/%b/%0d want %h/%b/%0d", c, result_out, status_out, tag_out, q[0].r, q[0].s, q[0].t);
        else passed++;
      end
      tick();
      total++; if (usage !== 3'(q.size())) $display("FAIL rnd_usage c=%0d: got %0d want %0d", c, usage, q.size()); else passed++;
      total++; if (fflags !== m_flags) $display("FAIL rnd_fflags c=%0d: got %b want %b", c, fflags, m_flags); else passed++;
    end
    idle();
  endtask

  initial begin
    status_in = '0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flag_clr();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
